// File: rtl/nn_pkg.sv
// Shared definitions for the sequential neural-network layers: activation
// selectors, layer FSM encoding and fixed-point helpers.
package nn_pkg;

    localparam int ACT_LINEAR = 0;
    localparam int ACT_RELU   = 1;
    localparam int ACT_HSIG   = 2;

    // Working width of saturate(); callers sign-extend into it and truncate the result.
    localparam int SAT_W = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_ACT  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // clog2 that never returns 0, so single-entry selectors still get a 1-bit port.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp a signed value to the range of a signed w-bit word.
    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] x,
                                                         input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
        lo = -hi - SAT_W'(1);
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/pctn_mac.sv
// One perceptron: wide accumulator (bias preload + one MAC per cycle) followed by
// rescale, saturation and the selected activation into a registered result.
module pctn_mac
    import nn_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16,
    parameter int ACC_W    = 66,
    parameter int ACT_MODE = ACT_RELU
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic signed [WIDTH-1:0] i_bias,
    input  logic                    i_mac,
    input  logic signed [WIDTH-1:0] i_w,
    input  logic signed [WIDTH-1:0] i_k,
    input  logic                    i_act,
    output logic signed [WIDTH-1:0] o_res
);

    localparam int PROD_W = 2 * WIDTH;
    localparam int HS_W   = WIDTH + 2;

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [WIDTH-1:0]  r_res;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_bias_acc;
    logic signed [ACC_W-1:0]  w_scaled;
    logic signed [WIDTH-1:0]  w_r;
    logic signed [HS_W-1:0]   w_one;
    logic signed [HS_W-1:0]   w_hs;
    logic signed [WIDTH-1:0]  w_act;

    assign w_prod     = PROD_W'(i_w) * PROD_W'(i_k);
    assign w_bias_acc = ACC_W'(i_bias) <<< FRAC;
    assign w_scaled   = r_acc >>> FRAC;
    assign w_r        = WIDTH'(saturate(SAT_W'(w_scaled), WIDTH));

    // Hard-sigmoid is evaluated two bits wider so the +0.5 offset cannot wrap.
    assign w_one = HS_W'(1) <<< FRAC;
    assign w_hs  = (HS_W'(w_r) >>> 2) + (w_one >>> 1);

    always_comb begin
        // NOTE: every path of a combinational block must assign its outputs; the
        // leading default is what keeps this block from inferring a latch.
        w_act = w_r;
        case (ACT_MODE)
            ACT_RELU: begin
                if (w_r[WIDTH-1]) begin
                    w_act = '0;
                end
            end
            ACT_HSIG: begin
                if (w_hs[HS_W-1]) begin
                    w_act = '0;
                end else if (w_hs > w_one) begin
                    w_act = WIDTH'(w_one);
                end else begin
                    w_act = WIDTH'(w_hs);
                end
            end
            default: ;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement or process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_res <= '0;
        end else begin
            if (i_load) begin
                r_acc <= w_bias_acc;
            end else if (i_mac) begin
                r_acc <= r_acc + ACC_W'(w_prod);
            end
            if (i_act) begin
                r_res <= w_act;
            end
        end
    end

    assign o_res = r_res;

endmodule

// File: rtl/hidden_layer_seq.sv
// Sequential hidden layer: weight/bias register file, input latch, shared MAC
// sequencer FSM and the output handshake around NUM_PCTN pctn_mac instances.
module hidden_layer_seq
    import nn_pkg::*;
#(
    parameter int NUM_INPUT = 2,
    parameter int NUM_PCTN  = 3,
    parameter int WIDTH     = 32,
    parameter int FRAC      = 16,
    parameter int ACT_MODE  = ACT_RELU
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr,
    input  logic [width_of(NUM_PCTN)-1:0]      wr_pctn,
    input  logic [width_of(NUM_INPUT+1)-1:0]   wr_idx,
    input  logic signed [WIDTH-1:0]            wr_data,
    output logic                               wr_err,
    input  logic                               i_valid,
    output logic                               i_ready,
    input  logic [NUM_INPUT*WIDTH-1:0]         i_k,
    output logic                               o_valid,
    input  logic                               o_ready,
    output logic [NUM_PCTN*WIDTH-1:0]          o
);

    localparam int CW    = width_of(NUM_INPUT);
    localparam int ACC_W = 2 * WIDTH + width_of(NUM_INPUT + 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CW-1:0]           r_cnt;
    logic signed [WIDTH-1:0] r_k    [NUM_INPUT];
    logic signed [WIDTH-1:0] r_w    [NUM_PCTN][NUM_INPUT];
    logic signed [WIDTH-1:0] r_bias [NUM_PCTN];
    logic                    r_wr_err;

    logic                    w_wr_ok;
    logic                    w_bias_wr;
    logic                    w_load;
    logic                    w_mac;
    logic                    w_act;
    logic                    w_last;
    logic signed [WIDTH-1:0] w_k_sel;

    assign w_wr_ok   = wr && (r_state == ST_IDLE)
                       && (32'(wr_pctn) < NUM_PCTN) && (32'(wr_idx) <= NUM_INPUT);
    assign w_bias_wr = w_wr_ok && (32'(wr_idx) == NUM_INPUT);
    assign w_last    = (r_cnt == CW'(NUM_INPUT - 1));
    assign w_k_sel   = r_k[r_cnt];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_mac        = 1'b0;
        w_act        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_load       = 1'b1;
                    w_next_state = ST_MAC;
                end
            end
            ST_MAC: begin
                w_mac = 1'b1;
                if (w_last) begin
                    w_next_state = ST_ACT;
                end
            end
            ST_ACT: begin
                w_act        = 1'b1;
                w_next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (o_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            for (int j = 0; j < NUM_INPUT; j++) begin
                r_k[j] <= '0;
            end
        end else if (w_load) begin
            r_cnt <= '0;
            for (int j = 0; j < NUM_INPUT; j++) begin
                r_k[j] <= i_k[j*WIDTH +: WIDTH];
            end
        end else if (w_mac) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // NOTE: the weight file is a register array rather than a RAM so that reset
    // can clear it; a RAM-mapped array would have to be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PCTN; p++) begin
                r_bias[p] <= '0;
                for (int j = 0; j < NUM_INPUT; j++) begin
                    r_w[p][j] <= '0;
                end
            end
        end else if (w_wr_ok) begin
            for (int p = 0; p < NUM_PCTN; p++) begin
                if (32'(wr_pctn) == p) begin
                    if (w_bias_wr) begin
                        r_bias[p] <= wr_data;
                    end
                    for (int j = 0; j < NUM_INPUT; j++) begin
                        if (32'(wr_idx) == j) begin
                            r_w[p][j] <= wr_data;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr && !w_wr_ok;
        end
    end

    assign wr_err  = r_wr_err;
    assign i_ready = (r_state == ST_IDLE);
    assign o_valid = (r_state == ST_HOLD);

    for (genvar p = 0; p < NUM_PCTN; p++) begin : g_pctn
        logic signed [WIDTH-1:0] w_bias_fwd;

        // A bias written in the accept cycle is not in r_bias yet, so it is bypassed.
        assign w_bias_fwd = (w_bias_wr && (32'(wr_pctn) == p)) ? wr_data : r_bias[p];

        pctn_mac #(
            .WIDTH    (WIDTH),
            .FRAC     (FRAC),
            .ACC_W    (ACC_W),
            .ACT_MODE (ACT_MODE)
        ) u_mac (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_load),
            .i_bias (w_bias_fwd),
            .i_mac  (w_mac),
            .i_w    (r_w[p][r_cnt]),
            .i_k    (w_k_sel),
            .i_act  (w_act),
            .o_res  (o[p*WIDTH +: WIDTH])
        );
    end

endmodule
